io_gpio_evt_unit: RTL
=====================

IO_GPIO_EVT_UNIT -- requirements
Module: io_gpio_evt_unit

Interface
REQ-001 SHALL have parameter NUM_GPIOS, default 32, number of monitored pins (1..256).
REQ-002 SHALL have parameter DEB_W, default 8, debounce counter width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries (power of two, >=2).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 Ports SHALL be as follows:
- sys_clk_i  in  1  clock, all state on rising edge
- sys_rst_i  in  1  synchronous, active-high reset
- gpio_in  in  NUM_GPIOS  asynchronous pad inputs
- cfg_en_i  in  NUM_GPIOS  per-pin event enable
- cfg_mode_i  in  NUM_GPIOS x 2  per-pin mode: 00 rise, 01 fall, 10 both, 11 level-high
- cfg_deb_i  in  DEB_W  debounce stable-cycle count, shared by all pins
- gpio_deb_o  out  NUM_GPIOS  debounced pin values
- evt_valid_o  out  1  event available
- evt_data_o  out  8  pin index, zero-extended
- evt_ready_i  in  1  consumer accepts event
- irq_o  out  1  FIFO non-empty
- ovf_o  out  1  sticky overflow flag
- ovf_clr_i  in  1  clears ovf_o

Function
REQ-006 Each pin SHALL pass through a 2-flop synchroniser (sync1, sync2).
REQ-007 Debounce per pin:
- sync2 == deb: counter SHALL clear.
- sync2 != deb and counter == cfg_deb_i: deb SHALL take sync2 and counter SHALL clear.
- Otherwise the counter SHALL increment, saturating at all-ones.
REQ-008 With cfg_deb_i = 0, deb SHALL follow sync2 with one cycle of delay.
REQ-009 Qualifying event per pin: SHALL be evaluated by comparing deb against its previous-cycle value deb_q.
- rise: deb & ~deb_q
- fall: ~deb & deb_q
- both: deb ^ deb_q
- level-high: deb
- Events SHALL be ignored when cfg_en_i is low.
REQ-010 A qualifying event SHALL set the pin's pending bit on the next edge.
REQ-011 Each cycle the FIFO is not full, the lowest-index pending bit SHALL be granted: its index is pushed and its bit cleared. At most one push per cycle.
REQ-012 A new event and a grant on the same pin in the same cycle SHALL leave the bit set (set wins).
REQ-013 An edge-mode event on a pin whose bit is already set and not being granted SHALL set ovf_o. Level-high mode SHALL never set ovf_o.
REQ-014 ovf_clr_i SHALL clear ovf_o. A simultaneous new overflow SHALL win and keep ovf_o high.
REQ-015 cfg_en_i low SHALL clear that pin's pending bit on the next edge.
REQ-016 FIFO full: no grant SHALL occur and pending bits SHALL hold. A push SHALL NOT occur when full, even if a pop happens in the same cycle.
REQ-017 FIFO empty: evt_valid_o SHALL be 0 and evt_data_o SHALL be 0.
REQ-018 Pop SHALL occur on evt_valid_o & evt_ready_i. Simultaneous push and pop on a non-full, non-empty FIFO SHALL keep the count.
REQ-019 Read/write pointers SHALL wrap modulo FIFO_DEPTH. Full and empty SHALL be distinguished by an extra pointer bit.
REQ-020 Latency: with cfg_deb_i = D, pin enabled, FIFO empty and no other pending, if gpio_in changes before edge 0 (the edge sync1 captures it), evt_valid_o SHALL rise after edge 4+D.
REQ-021 irq_o SHALL equal ~empty. gpio_deb_o SHALL equal deb.

Reset
REQ-022 While sys_rst_i is high at a clock edge, the following SHALL clear to 0: sync1, sync2, deb, deb_q, counters, pending, FIFO pointers, ovf_o.
REQ-023 Consequently after reset: evt_valid_o=0, evt_data_o=0, irq_o=0, ovf_o=0, gpio_deb_o=0.
REQ-024 Reset mid-operation SHALL discard all pending and queued events. No event SHALL be produced for pins held high across reset deassertion until deb rises through debounce.

Structure
REQ-025 Package io_gpio_evt_pkg SHALL hold:
- mode enum typedef (MODE_RISE, MODE_FALL, MODE_BOTH, MODE_LEVEL)
- EVT_DATA_W = 8
REQ-026 The FIFO SHALL be sub-module io_evt_fifo (parameters DATA_W, DEPTH; synchronous active-high reset). All other logic SHALL be in io_gpio_evt_unit.

Verification
REQ-027 Latency: cfg_deb_i=0, pin 5 rise mode, gpio_in[5] 0->1 -> evt_valid_o after edge 4, evt_data_o=5, irq_o=1; evt_ready_i=1 -> empty next cycle.
REQ-028 Debounce: cfg_deb_i=3, pin 2 glitch high for 3 cycles -> no event. Then held high 6 cycles -> gpio_deb_o[2]=1 and one event, data=2.
REQ-029 Priority: pins 7, 1, 4 rise in the same cycle, evt_ready_i=1 -> events in order 1, 4, 7 on consecutive cycles.
REQ-030 Full/overflow: FIFO_DEPTH=4, evt_ready_i=0, pins 0-5 rise (both mode) -> 4 entries 0-3; pins 4 and 5 stay pending; pin 4 falls -> ovf_o=1. Pulse ovf_clr_i -> ovf_o=0. Pop all -> 4, 5 follow.
REQ-031 Reset mid-stream: 3 queued events, sys_rst_i high 1 cycle -> evt_valid_o=0, ovf_o=0 next cycle; no stale events thereafter.
REQ-032 Level mode: pin 3 level-high held high, evt_ready_i=1 -> continuous index-3 events, ovf_o stays 0; cfg_en_i[3]=0 -> events stop after queued entries drain.

Source files
------------

// File: rtl/io_gpio_evt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : io_gpio_evt_pkg
//  Purpose  : Shared types and constants for the GPIO event unit.
//  Revision : 1.0 - initial release
// ============================================================================
package io_gpio_evt_pkg;

    typedef enum logic [1:0] {
        MODE_RISE  = 2'b00,
        MODE_FALL  = 2'b01,
        MODE_BOTH  = 2'b10,
        MODE_LEVEL = 2'b11
    } gpio_mode_e;

    localparam int EVT_DATA_W = 8;

endpackage
`default_nettype wire

// File: rtl/io_evt_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : io_evt_fifo
//  Purpose  : Event FIFO; extra pointer bit separates full from empty.
//  Revision : 1.0 - initial release
// ============================================================================
module io_evt_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = AW + 1;

    logic [PW-1:0]     r_wptr_q, w_wptr_d;
    logic [PW-1:0]     r_rptr_q, w_rptr_d;
    logic [DATA_W-1:0] r_mem_q [DEPTH];
    logic [DATA_W-1:0] w_mem_d [DEPTH];
    logic              w_full, w_empty, w_wr, w_rd;

    assign w_empty = (r_wptr_q == r_rptr_q);
    assign w_full  = (r_wptr_q[AW] != r_rptr_q[AW]) &&
                     (r_wptr_q[AW-1:0] == r_rptr_q[AW-1:0]);
    // A pop in the same cycle does not make room for a push while full.
    assign w_wr    = i_push & ~w_full;
    assign w_rd    = i_pop & ~w_empty;

    always_comb begin
        w_mem_d  = r_mem_q;
        w_wptr_d = r_wptr_q;
        w_rptr_d = r_rptr_q;
        if (w_wr) begin
            w_mem_d[r_wptr_q[AW-1:0]] = i_data;
            w_wptr_d = r_wptr_q + PW'(1);
        end
        if (w_rd) begin
            w_rptr_d = r_rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr_q <= '0;
            r_rptr_q <= '0;
        end else begin
            r_wptr_q <= w_wptr_d;
            r_rptr_q <= w_rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        r_mem_q <= w_mem_d;
    end

    assign o_data  = w_empty ? '0 : r_mem_q[r_rptr_q[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/io_gpio_evt_unit.sv
`default_nettype none
// ============================================================================
//  Module   : io_gpio_evt_unit
//  Purpose  : Per-pin sync/debounce/edge detect, priority grant into event FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module io_gpio_evt_unit
    import io_gpio_evt_pkg::*;
#(
    parameter int NUM_GPIOS  = 32,
    parameter int DEB_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   sys_clk_i,
    input  logic                   sys_rst_i,
    input  logic [NUM_GPIOS-1:0]   gpio_in,
    input  logic [NUM_GPIOS-1:0]   cfg_en_i,
    input  logic [2*NUM_GPIOS-1:0] cfg_mode_i,
    input  logic [DEB_W-1:0]       cfg_deb_i,
    output logic [NUM_GPIOS-1:0]   gpio_deb_o,
    output logic                   evt_valid_o,
    output logic [EVT_DATA_W-1:0]  evt_data_o,
    input  logic                   evt_ready_i,
    output logic                   irq_o,
    output logic                   ovf_o,
    input  logic                   ovf_clr_i
);

    logic [NUM_GPIOS-1:0]            r_sync1_q, r_sync2_q;
    logic [NUM_GPIOS-1:0]            r_deb_q, w_deb_d;
    logic [NUM_GPIOS-1:0]            r_deb_prev_q;
    logic [NUM_GPIOS-1:0][DEB_W-1:0] r_cnt_q, w_cnt_d;
    logic [NUM_GPIOS-1:0]            r_pend_q, w_pend_d;
    logic                            r_ovf_q, w_ovf_d;

    logic [NUM_GPIOS-1:0]  w_evt, w_edge_mode, w_gnt;
    logic [EVT_DATA_W-1:0] w_push_idx;
    logic                  w_push, w_pop, w_fifo_full, w_fifo_empty;

    always_comb begin
        w_deb_d = r_deb_q;
        w_cnt_d = r_cnt_q;
        for (int i = 0; i < NUM_GPIOS; i++) begin
            if (r_sync2_q[i] == r_deb_q[i]) begin
                w_cnt_d[i] = '0;
            end else if (r_cnt_q[i] == cfg_deb_i) begin
                w_deb_d[i] = r_sync2_q[i];
                w_cnt_d[i] = '0;
            end else if (!(&r_cnt_q[i])) begin
                w_cnt_d[i] = r_cnt_q[i] + DEB_W'(1);
            end
        end
    end

    always_comb begin
        w_evt       = '0;
        w_edge_mode = '0;
        for (int i = 0; i < NUM_GPIOS; i++) begin
            case (gpio_mode_e'(cfg_mode_i[2*i +: 2]))
                MODE_RISE: w_evt[i] = r_deb_q[i] & ~r_deb_prev_q[i];
                MODE_FALL: w_evt[i] = ~r_deb_q[i] & r_deb_prev_q[i];
                MODE_BOTH: w_evt[i] = r_deb_q[i] ^ r_deb_prev_q[i];
                default:   w_evt[i] = r_deb_q[i];
            endcase
            w_edge_mode[i] = (gpio_mode_e'(cfg_mode_i[2*i +: 2]) != MODE_LEVEL);
        end
        w_evt = w_evt & cfg_en_i;
    end

    // Lowest pending index wins; nothing is granted while the FIFO is full.
    always_comb begin
        logic found;
        found      = 1'b0;
        w_gnt      = '0;
        w_push_idx = '0;
        if (!w_fifo_full) begin
            for (int i = 0; i < NUM_GPIOS; i++) begin
                if (r_pend_q[i] && !found) begin
                    found      = 1'b1;
                    w_gnt[i]   = 1'b1;
                    w_push_idx = EVT_DATA_W'(i);
                end
            end
        end
    end

    assign w_push   = |w_gnt;
    assign w_pend_d = ((r_pend_q & ~w_gnt) | w_evt) & cfg_en_i;
    assign w_ovf_d  = (|(w_evt & w_edge_mode & r_pend_q & ~w_gnt)) |
                      (r_ovf_q & ~ovf_clr_i);

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_sync1_q    <= '0;
            r_sync2_q    <= '0;
            r_deb_q      <= '0;
            r_deb_prev_q <= '0;
            r_cnt_q      <= '0;
            r_pend_q     <= '0;
            r_ovf_q      <= 1'b0;
        end else begin
            r_sync1_q    <= gpio_in;
            r_sync2_q    <= r_sync1_q;
            r_deb_q      <= w_deb_d;
            r_deb_prev_q <= r_deb_q;
            r_cnt_q      <= w_cnt_d;
            r_pend_q     <= w_pend_d;
            r_ovf_q      <= w_ovf_d;
        end
    end

    io_evt_fifo #(
        .DATA_W (EVT_DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk_i),
        .rst     (sys_rst_i),
        .i_push  (w_push),
        .i_data  (w_push_idx),
        .i_pop   (w_pop),
        .o_data  (evt_data_o),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign evt_valid_o = ~w_fifo_empty;
    assign w_pop       = evt_valid_o & evt_ready_i;
    assign irq_o       = ~w_fifo_empty;
    assign ovf_o       = r_ovf_q;
    assign gpio_deb_o  = r_deb_q;

endmodule
`default_nettype wire
